// File: rtl/lm_sm_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// risc_defs
//   Shared definitions for the pipelined RISC decode/register-read stage.
//   Holds the LM/SM opcodes, the register-file and word widths, the
//   sequencer state enum and a small list-manipulation helper.
// -----------------------------------------------------------------------------
package risc_defs;

    localparam logic [3:0] OP_LM = 4'b0110;
    localparam logic [3:0] OP_SM = 4'b0111;

    localparam int REG_ADDR_W = 3;
    localparam int REG_LIST_W = 8;
    localparam int WORD_W     = 16;

    typedef logic [REG_ADDR_W-1:0] regAddrT;
    typedef logic [REG_LIST_W-1:0] regListT;
    typedef logic [WORD_W-1:0]     wordT;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seqStateT;

    // Remove one register from a list once its micro-op has been issued.
    function automatic regListT clearBit(input regListT list, input regAddrT idx);
        return list & ~(regListT'(1) << idx);
    endfunction

endpackage

// File: rtl/lm_sm_sequencer_if.sv
// -----------------------------------------------------------------------------
// lm_sm_sequencer_if
//   Bundles the decode-side request, the downstream stall and the micro-op
//   outputs of the LM/SM sequencer.
//   master : decode/downstream side (drives start, isStore, regList,
//            baseAddr, stall; observes busy and the micro-op fields)
//   slave  : the sequencer itself
// -----------------------------------------------------------------------------
interface lm_sm_sequencer_if;
    import risc_defs::*;

    logic    start;
    logic    isStore;
    regListT regList;
    wordT    baseAddr;
    logic    stall;

    logic    busy;
    logic    uopValid;
    logic    uopIsStore;
    regAddrT uopReg;
    wordT    uopAddr;
    logic    uopLast;
    logic    done;

    modport master (
        output start, isStore, regList, baseAddr, stall,
        input  busy, uopValid, uopIsStore, uopReg, uopAddr, uopLast, done
    );

    modport slave (
        input  start, isStore, regList, baseAddr, stall,
        output busy, uopValid, uopIsStore, uopReg, uopAddr, uopLast, done
    );

endinterface

// File: rtl/lm_sm_sequencer_lsb.sv
// -----------------------------------------------------------------------------
// lowest_set_bit
//   Combinational 8-to-3 priority encoder: returns the index of the lowest
//   set bit of a register list, with found=0 when the list is empty.
//   Ports: bits (in, list), index (out, lowest set position), found (out).
// -----------------------------------------------------------------------------
module lowest_set_bit
    import risc_defs::*;
(
    input  regListT bits,
    output regAddrT index,
    output logic    found
);

    // NOTE: give every always_comb output a default first; any path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        found = 1'b0;
        index = '0;
        // Scan from the top down so the last hit, the lowest bit, wins.
        for (int i = REG_LIST_W - 1; i >= 0; i--) begin
            if (bits[i]) begin
                found = 1'b1;
                index = regAddrT'(i);
            end
        end
    end

endmodule

// File: rtl/lm_sm_sequencer.sv
// -----------------------------------------------------------------------------
// lm_sm_sequencer
//   Expands a decoded Load-Multiple / Store-Multiple instruction into one
//   single-register micro-op per cycle, lowest register first, with the
//   memory address rising by one (mod 2^16) per transfer. Holds decode busy
//   while expanding and pulses done once the final micro-op is accepted.
//   Ports: clk, reset (sync, active-high), bus (lm_sm_sequencer_if.slave).
//   All outputs come straight from flops.
// -----------------------------------------------------------------------------
module lm_sm_sequencer
    import risc_defs::*;
(
    input  logic               clk,
    input  logic               reset,
    lm_sm_sequencer_if.slave   bus
);

    seqStateT state;
    regListT  remaining;
    wordT     curAddr;
    regAddrT  uopReg;
    logic     uopLast;
    logic     uopIsStore;
    logic     done;

    regAddrT  listIdx;
    logic     listFound;
    regAddrT  remIdx;
    logic     remFound;
    regListT  listCleared;
    regListT  remCleared;

    lowest_set_bit uListEnc (
        .bits  (bus.regList),
        .index (listIdx),
        .found (listFound)
    );

    lowest_set_bit uRemEnc (
        .bits  (remaining),
        .index (remIdx),
        .found (remFound)
    );

    assign listCleared = clearBit(bus.regList, listIdx);
    assign remCleared  = clearBit(remaining, remIdx);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            remaining  <= '0;
            curAddr    <= '0;
            uopReg     <= '0;
            uopLast    <= 1'b0;
            uopIsStore <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (listFound) begin
                            state      <= RUN;
                            uopReg     <= listIdx;
                            curAddr    <= bus.baseAddr;
                            remaining  <= listCleared;
                            uopLast    <= (listCleared == '0);
                            uopIsStore <= bus.isStore;
                        end else begin
                            // Empty list: nothing to transfer, just retire.
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (!bus.stall) begin
                        // remFound is always set when uopLast is clear; the
                        // extra term just keeps an empty remainder from
                        // issuing a bogus micro-op.
                        if (uopLast || !remFound) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            uopReg    <= remIdx;
                            curAddr   <= curAddr + wordT'(1);
                            remaining <= remCleared;
                            uopLast   <= (remCleared == '0);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy       = (state == RUN);
    assign bus.uopValid   = (state == RUN);
    assign bus.uopIsStore = uopIsStore;
    assign bus.uopReg     = uopReg;
    assign bus.uopAddr    = curAddr;
    assign bus.uopLast    = uopLast;
    assign bus.done       = done;

endmodule
